// File: rtl/instruction_loader.sv
// Assembles UART RX bytes into big-endian instruction words, writes them into the
// pipeline instruction memory, and releases the pipeline once the HALT word lands.
module instruction_loader #(
    parameter int                 NB_DATA    = 32,
    parameter int                 NB_BYTE    = 8,
    parameter int                 MAX_WORDS  = 256,
    parameter int                 NB_COUNT   = 9,
    parameter int                 RST_CYCLES = 2,
    parameter logic [NB_DATA-1:0] HALT_WORD  = {NB_DATA{1'b1}}
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_load_cmd,
    output logic                o_we_IF,
    output logic [NB_DATA-1:0]  o_instruction_data,
    output logic                o_pipe_rst_n,
    output logic                o_halt,
    output logic [NB_COUNT-1:0] o_word_count,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    localparam int BYTES   = NB_DATA / NB_BYTE;
    localparam int NB_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int NB_RCNT = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [NB_BCNT-1:0]  LAST_BYTE = NB_BCNT'(BYTES - 1);
    localparam logic [NB_RCNT-1:0]  LAST_RST  = NB_RCNT'(RST_CYCLES - 1);
    localparam logic [NB_COUNT-1:0] MAX_CNT   = NB_COUNT'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        PIPE_RST,
        RUN,
        ERROR
    } state_t;

    state_t state, next_state;

    logic [NB_BCNT-1:0]         byte_cnt;
    logic [NB_RCNT-1:0]         rst_cnt;
    logic [NB_DATA-NB_BYTE-1:0] shift_reg;
    logic [NB_DATA-1:0]         assembled;
    logic [NB_COUNT-1:0]        count_inc;
    logic                       last_byte;
    logic                       is_halt;
    logic                       pipe_rst_n_d;
    logic                       halt_d;
    logic                       busy_d;
    logic                       done_d;
    logic                       error_d;

    assign assembled = {shift_reg, i_rx_data};
    assign count_inc = o_word_count + NB_COUNT'(1);
    assign last_byte = i_rx_valid && (byte_cnt == LAST_BYTE);
    assign is_halt   = (o_instruction_data == HALT_WORD);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // HALT takes priority over the memory-full check, so a HALT in the last slot still runs.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (i_load_cmd) next_state = LOAD;
            LOAD:     if (last_byte) next_state = WRITE;
            WRITE: begin
                if (is_halt) begin
                    next_state = PIPE_RST;
                end else if (count_inc == MAX_CNT) begin
                    next_state = ERROR;
                end else begin
                    next_state = LOAD;
                end
            end
            PIPE_RST: if (rst_cnt == LAST_RST) next_state = RUN;
            RUN:      if (i_load_cmd) next_state = LOAD;
            ERROR:    if (i_load_cmd) next_state = LOAD;
            default:  next_state = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so the registered copies track the state.
    always_comb begin
        pipe_rst_n_d = 1'b1;
        halt_d       = 1'b1;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        case (next_state)
            IDLE:     pipe_rst_n_d = 1'b0;
            LOAD:     busy_d = 1'b1;
            WRITE:    busy_d = 1'b1;
            PIPE_RST: begin
                pipe_rst_n_d = 1'b0;
                halt_d       = 1'b0;
            end
            RUN: begin
                halt_d = 1'b0;
                done_d = 1'b1;
            end
            ERROR:    error_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_we_IF            <= 1'b0;
            o_instruction_data <= '0;
            o_word_count       <= '0;
            o_pipe_rst_n       <= 1'b0;
            o_halt             <= 1'b1;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_error            <= 1'b0;
            byte_cnt           <= '0;
            rst_cnt            <= '0;
            shift_reg          <= '0;
        end else begin
            o_pipe_rst_n <= pipe_rst_n_d;
            o_halt       <= halt_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
            o_error      <= error_d;
            o_we_IF      <= (state == LOAD) && last_byte;
            case (state)
                IDLE, RUN, ERROR: begin
                    if (i_load_cmd) begin
                        o_word_count <= '0;
                        byte_cnt     <= '0;
                    end
                end
                LOAD: begin
                    if (i_rx_valid) begin
                        shift_reg <= assembled[NB_DATA-NB_BYTE-1:0];
                        byte_cnt  <= last_byte ? '0 : byte_cnt + NB_BCNT'(1);
                        if (last_byte) begin
                            o_instruction_data <= assembled;
                        end
                    end
                end
                WRITE: begin
                    o_word_count <= count_inc;
                    rst_cnt      <= '0;
                    // A byte arriving during the write pulse already belongs to the next word.
                    if (i_rx_valid && (next_state == LOAD)) begin
                        shift_reg <= assembled[NB_DATA-NB_BYTE-1:0];
                        byte_cnt  <= NB_BCNT'(1);
                    end
                end
                PIPE_RST: rst_cnt <= rst_cnt + NB_RCNT'(1);
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default-size instance plus a 4-word
// instance that shares all inputs so the memory-full path can be exercised.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load_cmd;

    logic        we, pipe_rst_n, halt, busy, done, error;
    logic [31:0] data;
    logic [8:0]  wc;

    logic        we4, pipe_rst_n4, halt4, busy4, done4, error4;
    logic [31:0] data4;
    logic [2:0]  wc4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    instruction_loader dut (
        .clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_load_cmd(load_cmd), .o_we_IF(we), .o_instruction_data(data),
        .o_pipe_rst_n(pipe_rst_n), .o_halt(halt), .o_word_count(wc),
        .o_busy(busy), .o_done(done), .o_error(error)
    );

    instruction_loader #(.MAX_WORDS(4), .NB_COUNT(3)) dut4 (
        .clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_load_cmd(load_cmd), .o_we_IF(we4), .o_instruction_data(data4),
        .o_pipe_rst_n(pipe_rst_n4), .o_halt(halt4), .o_word_count(wc4),
        .o_busy(busy4), .o_done(done4), .o_error(error4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Passive capture of write pulses (data, start cycle, width) and pipeline-reset length.
    logic [31:0] wq[$];
    int          tq[$];
    int          lq[$];
    int          run_len = 0;
    logic        we_d = 1'b0;
    int          rstlow = 0;
    int          we4_cnt = 0;

    always @(negedge clk) begin
        if (we) begin
            if (!we_d) begin
                wq.push_back(data);
                tq.push_back(cyc);
            end
            run_len++;
        end else if (we_d) begin
            lq.push_back(run_len);
            run_len = 0;
        end
        we_d = we;
        if (!pipe_rst_n && !halt) rstlow++;
        if (we4) we4_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_load;
        load_cmd = 1'b1;
        tick();
        load_cmd = 1'b0;
    endtask

    task automatic clear_mon;
        wq.delete();
        tq.delete();
        lq.delete();
        rstlow  = 0;
        we4_cnt = 0;
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 60 && !done; i++) tick();
        ok = done;
    endtask

    function automatic logic [31:0] word_at(input int idx);
        return (wq.size() > idx) ? wq[idx] : 32'hDEADBEEF;
    endfunction

    task automatic test_reset;
        logic [5:0] flags;
        rst_n = 1'b0; rx_valid = 1'b0; load_cmd = 1'b0; rx_data = 8'h00;
        repeat (3) tick();
        flags = {we, pipe_rst_n, halt, busy, done, error};
        total++; if (flags !== 6'b001000) begin bad++; $display("FAIL reset_flags got=%b want=001000", flags); end
        total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", data); end
        total++; if (wc !== 9'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", wc); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic [5:0] flags;
        bit ok;
        clear_mon();
        pulse_load();
        flags = {we, pipe_rst_n, halt, busy, done, error};
        total++; if (flags !== 6'b011100) begin bad++; $display("FAIL load_flags got=%b want=011100", flags); end
        send_word(32'h2001000F, 3);
        send_word(32'hFFFFFFFF, 3);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=0 want=1"); end
        total++; if (wq.size() !== 2) begin bad++; $display("FAIL basic_writes got=%0d want=2", wq.size()); end
        total++; if (word_at(0) !== 32'h2001000F) begin bad++; $display("FAIL basic_word0 got=%h want=2001000f", word_at(0)); end
        total++; if (word_at(1) !== 32'hFFFFFFFF) begin bad++; $display("FAIL basic_word1 got=%h want=ffffffff", word_at(1)); end
        total++; if (lq.size() !== 2 || lq[0] !== 1 || lq[1] !== 1) begin bad++; $display("FAIL basic_pulse_width got_n=%0d want 2 pulses of 1", lq.size()); end
        total++; if (wc !== 9'd2) begin bad++; $display("FAIL basic_count got=%0d want=2", wc); end
        total++; if (rstlow !== 2) begin bad++; $display("FAIL basic_rst_len got=%0d want=2", rstlow); end
        flags = {we, pipe_rst_n, halt, busy, done, error};
        total++; if (flags !== 6'b010010) begin bad++; $display("FAIL run_flags got=%b want=010010", flags); end
    endtask

    task automatic test_run_reload;
        logic [5:0] flags;
        pulse_load();
        flags = {we, pipe_rst_n, halt, busy, done, error};
        total++; if (flags !== 6'b011100) begin bad++; $display("FAIL reload_flags got=%b want=011100", flags); end
        total++; if (wc !== 9'd0) begin bad++; $display("FAIL reload_count got=%0d want=0", wc); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int gap;
        clear_mon();
        send_word(32'hA0010000, 1);
        send_word(32'hFFFFFFFF, 1);
        wait_done(ok);
        gap = (tq.size() == 2) ? tq[1] - tq[0] : -1;
        total++; if (!ok) begin bad++; $display("FAIL b2b_done_timeout got=0 want=1"); end
        total++; if (word_at(0) !== 32'hA0010000) begin bad++; $display("FAIL b2b_word0 got=%h want=a0010000", word_at(0)); end
        total++; if (word_at(1) !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_word1 got=%h want=ffffffff", word_at(1)); end
        total++; if (gap !== 4) begin bad++; $display("FAIL b2b_spacing got=%0d want=4", gap); end
        total++; if (wc !== 9'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", wc); end
    endtask

    task automatic test_error;
        pulse_load();
        clear_mon();
        send_word(32'h11111111, 1);
        send_word(32'h22222222, 1);
        send_word(32'h33333333, 1);
        send_word(32'h44444444, 1);
        repeat (2) tick();
        total++; if (error4 !== 1'b1) begin bad++; $display("FAIL full_error got=%b want=1", error4); end
        total++; if (wc4 !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", wc4); end
        total++; if (we4_cnt !== 4) begin bad++; $display("FAIL full_writes got=%0d want=4", we4_cnt); end
        send_word(32'h55555555, 1);
        repeat (2) tick();
        total++; if (we4_cnt !== 4) begin bad++; $display("FAIL full_extra_write got=%0d want=4", we4_cnt); end
        total++; if (wc4 !== 3'd4 || error4 !== 1'b1) begin bad++; $display("FAIL full_hold got=%0d/%b want=4/1", wc4, error4); end
        pulse_load();
        total++; if ({error4, busy4, wc4} !== {1'b0, 1'b1, 3'd0}) begin bad++; $display("FAIL full_clear got=%b%b/%0d want=01/0", error4, busy4, wc4); end
        send_word(32'h66666666, 1);
        send_word(32'h77777777, 1);
        send_word(32'h88888888, 1);
        send_word(32'hFFFFFFFF, 1);
        for (int i = 0; i < 20 && !done4; i++) tick();
        total++; if ({done4, error4, wc4} !== {1'b1, 1'b0, 3'd4}) begin bad++; $display("FAIL halt_last_slot got=%b%b/%0d want=10/4", done4, error4, wc4); end
        total++; if ({done, wc} !== {1'b1, 9'd9}) begin bad++; $display("FAIL load_cmd_ignored got=%b/%0d want=1/9", done, wc); end
    endtask

    task automatic test_reset_midload;
        logic [5:0] flags;
        bit ok;
        pulse_load();
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 1);
        rst_n = 1'b0;
        repeat (2) tick();
        flags = {we, pipe_rst_n, halt, busy, done, error};
        total++; if (flags !== 6'b001000) begin bad++; $display("FAIL midreset_flags got=%b want=001000", flags); end
        total++; if (data !== 32'h0 || wc !== 9'd0) begin bad++; $display("FAIL midreset_regs got=%h/%0d want=0/0", data, wc); end
        rst_n = 1'b1;
        tick();
        clear_mon();
        pulse_load();
        send_word(32'h8C030008, 2);
        send_word(32'hFFFFFFFF, 2);
        wait_done(ok);
        total++; if (word_at(0) !== 32'h8C030008) begin bad++; $display("FAIL midreset_word0 got=%h want=8c030008", word_at(0)); end
        total++; if (!ok || wc !== 9'd2) begin bad++; $display("FAIL midreset_count got=%0d want=2", wc); end
    endtask

    task automatic test_idle_ignore;
        logic [5:0] flags;
        bit ok;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 1);
        tick();
        flags = {we, pipe_rst_n, halt, busy, done, error};
        total++; if (wq.size() !== 0 || wc !== 9'd0) begin bad++; $display("FAIL idle_writes got=%0d/%0d want=0/0", wq.size(), wc); end
        total++; if (flags !== 6'b001000) begin bad++; $display("FAIL idle_flags got=%b want=001000", flags); end
        pulse_load();
        send_word(32'h12345678, 1);
        send_word(32'hFFFFFFFF, 1);
        wait_done(ok);
        total++; if (word_at(0) !== 32'h12345678) begin bad++; $display("FAIL idle_next_word got=%h want=12345678", word_at(0)); end
        total++; if (!ok || wc !== 9'd2) begin bad++; $display("FAIL idle_next_count got=%0d want=2", wc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_run_reload();
        test_back_to_back();
        test_error();
        test_reset_midload();
        test_idle_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
